if_fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
- Generates the PC and issues one outstanding request at a time to instruction memory over a valid/ready request channel with a variable-latency response.
- Holds the IF/ID register under the load-use stall from the hazard unit.
- Flushes on branch/jump redirect from EX.
- Drives if_id_rs1/rs2/opcode directly into the stall-detect logic.

---
 rtl/if_fetch_stage_if.sv | 27 ++
 rtl/if_fetch_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One outstanding request at a time; response is a single-cycle pulse.
interface if_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I fetch stage: PC generation, single-outstanding imem fetch, one-entry
// hold buffer for responses that land during a stall, and the IF/ID register.
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    if_fetch_stage_if.master imem,
    output logic             if_id_valid,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic [4:0]       if_id_opcode,
    output logic [4:0]       if_id_rs1,
    output logic [4:0]       if_id_rs2
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] saved_pc;
    logic            kill;
    logic [XLEN-1:0] hold_pc;
    logic [31:0]     hold_instr;
    logic [XLEN-1:0] redirect_target;
    logic            load_fetch;
    logic            load_hold;

    assign redirect_target = redirect_pc & ~XLEN'(3);

    assign imem.imem_req_valid = rst_n && (state == S_REQ) && !redirect_valid;
    assign imem.imem_req_addr  = pc;

    assign load_fetch = (state == S_WAIT) && imem.imem_rsp_valid && !kill
                        && !redirect_valid && !stall;
    assign load_hold  = (state == S_HOLD) && !redirect_valid && !stall;

    // A bubble holds NOP, so these decode as addi x0 and never trigger a stall.
    assign if_id_opcode = if_id_instr[6:2];
    assign if_id_rs1    = if_id_instr[19:15];
    assign if_id_rs2    = if_id_instr[24:20];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            saved_pc    <= '0;
            kill        <= 1'b0;
            hold_pc     <= '0;
            hold_instr  <= NOP;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end else if (imem.imem_req_ready) begin
                        saved_pc <= pc;
                        pc       <= pc + XLEN'(4);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    // A redirect with no response yet poisons the in-flight fetch.
                    if (imem.imem_rsp_valid) begin
                        kill <= 1'b0;
                        if (!kill && !redirect_valid && stall) begin
                            hold_pc    <= saved_pc;
                            hold_instr <= imem.imem_rsp_data;
                            state      <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= S_REQ;
                    end else if (!stall) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // Flush beats stall; stall beats any new load.
            if (redirect_valid) begin
                if_id_valid <= 1'b0;
                if_id_pc    <= '0;
                if_id_instr <= NOP;
            end else if (stall) begin
                if_id_valid <= if_id_valid;
            end else if (load_fetch) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= saved_pc;
                if_id_instr <= imem.imem_rsp_data;
            end else if (load_hold) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= hold_pc;
                if_id_instr <= hold_instr;
            end else begin
                if_id_valid <= 1'b0;
                if_id_pc    <= '0;
                if_id_instr <= NOP;
            end
        end
    end
endmodule
